wlm_red_pipe: RTL and testbench
===============================

Name: wlm_red_pipe

Overview:
- Elastic, fully pipelined word-level Montgomery reducer for NTT-friendly moduli of the form q = qH·2^W + 1.
- The iteration count is generic, derived from LOGQ and W. The modulus is selected per request from an internal NQ-entry qH table. Requests use a valid/ready handshake and carry a tag.
- Sits between the 2·LOGQ-bit multiplier output and the butterfly/accumulator units, so one instance serves several moduli (RNS channels).

Parameters:
- LOGQ, 60, modulus bit width; input C is 2·LOGQ bits.
- W, 17, word size reduced per iteration; qH width is LOGQ-W.
- NQ, 4, number of qH table entries; QIDX_W = max(1, clog2(NQ)).
- TAG_W, 8, width of the opaque tag carried alongside each request.
- FF_OUT, 1, adds a registered output stage after the final subtract when 1; 0 makes the subtract output combinational to the output register.
- Derived, not overridable: N_ITER = ceil(LOGQ/W); LAT = N_ITER + 1 + FF_OUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  qH table write strobe.
- cfg_idx  in  QIDX_W  table entry to write.
- cfg_qh  in  LOGQ-W  qH value to write.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_c  in  2·LOGQ  operand C; precondition C < q².
- in_qidx  in  QIDX_W  modulus selector.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_t  out  LOGQ  result T = C·2^(-W·N_ITER) mod q, with 0 ≤ T < q.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  one or more requests in flight.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All valid bits, out_valid, busy and the occupancy counter go to 0.
  - The qH table resets to all zeros.
  - Data and tag registers are not reset; out_t and out_tag are don't-care while out_valid=0.
- Pipeline enable: en = !out_valid || out_ready; in_ready = en.
  - When en=0, every stage holds, including its valid bit.
  - When en=1, all stages advance together; bubbles advance like data.
- Acceptance:
  - On acceptance, stage 0 captures C, tag and qH = table[in_qidx].
  - The qH value travels with the request. Table writes never affect requests already accepted.
  - cfg_we in the same cycle as an acceptance that reads the same index: the request uses the old value.
  - cfg_idx ≥ NQ: the write is ignored.
  - in_qidx ≥ NQ: the request uses entry 0.
- Iteration i (registered, one stage each), operating on Ti:
  - lo = Ti[W-1:0]; m = (2^W - lo) mod 2^W.
  - Ti+1 = (Ti >> W) + m·qH + (lo != 0).
  - Each stage's width is sized to hold the worst case without overflow. The final iterate is < 2q.
- Final stage: T = (Tn ≥ q) ? Tn - q : Tn, where q = {qH, W'b1} with a W-bit word, i.e. qH·2^W + 1.
- Latency: an accepted request appears on out_valid exactly LAT cycles later, provided out_ready stays 1.
  - Throughput is 1 result per cycle.
  - Results leave in acceptance order with their tag.
- Occupancy counter, 0..LAT:
  - Increments on acceptance without output transfer.
  - Decrements on output transfer without acceptance.
  - Holds when both or neither happen.
  - busy = (count != 0).
- Backpressure: out_valid and out_t stay stable while out_ready=0. No result is dropped or duplicated.
- Reset mid-operation flushes all in-flight requests; no output follows.

Decomposition:
- Shared package wlm_pkg holds:
  - the function wlm_n_iter(LOGQ, W);
  - the function wlm_stage_width(LOGQ, W, i);
  - the function wlm_lat(LOGQ, W, FF_OUT);
  - the typedef wlm_req_t {c, qh, tag, valid}.
- One sub-module, wlm_word_step: a single enabled, registered iteration carrying qH, tag and valid, instanced N_ITER times in a generate loop.
- The qH table, final subtract and handshake stay in the top module.

Test Plan:
- Write table[0]=3, table[1]=5 (q=393217 and q=655361); send C=0 on idx 0, then C=393217 on idx 0 -> out_t=0 twice, after exactly LAT=6 cycles each, with tags preserved.
- Send 1000 random back-to-back C < q² across idx 0..1 with out_ready=1 -> out_t equals the golden model C·2^(-68) mod q; one result per cycle; order kept.
- Random out_ready, 30% low -> no loss or duplication; out_t and out_tag stable while stalled; in_ready equals !out_valid || out_ready.
- Rewrite table[0]=7 in the same cycle as an idx-0 request, then send a second idx-0 request -> the first result uses q=393217, the second uses q=917505.
- Assert rst_n low with 4 requests in flight -> out_valid=0 and busy=0 immediately; no result after release.
- C = q²-1 on idx 1 -> result < q and equal to the model, exercising the final subtract and the maximum stage widths.

Source files
------------

// File: rtl/wlm_red_pipe_pkg.sv
// wlm_pkg: shared sizing helpers and request type for the word-level Montgomery reducer
package wlm_pkg;
  localparam int WLM_LOGQ = 60;
  localparam int WLM_W = 17;
  localparam int WLM_TAG_W = 8;
  typedef struct packed {
    logic [2*WLM_LOGQ-1:0] c;
    logic [WLM_LOGQ-WLM_W-1:0] qh;
    logic [WLM_TAG_W-1:0] tag;
    logic valid;
  } wlm_req_t;
  function automatic int wlm_n_iter(input int logq, input int w);
    return (logq + w - 1) / w;
  endfunction
  // Iterate i stays below 2^(2*logq - w*i) + 2q; the final iterate is below 2q
  function automatic int wlm_stage_width(input int logq, input int w, input int i);
    int body;
    body = (2 * logq - w * i > logq + 1) ? 2 * logq - w * i : logq + 1;
    return (i == 0) ? 2 * logq : (i >= wlm_n_iter(logq, w)) ? logq + 1 : body + 1;
  endfunction
  function automatic int wlm_lat(input int logq, input int w, input int ff_out);
    return wlm_n_iter(logq, w) + 1 + ff_out;
  endfunction
endpackage

// File: rtl/wlm_red_pipe_if.sv
// wlm_red_pipe_if: request/result handshake bundle for the Montgomery reducer
interface wlm_red_pipe_if #(
  parameter int LOGQ = 60,
  parameter int QIDX_W = 2,
  parameter int TAG_W = 8
);
  logic in_valid, in_ready;
  logic [2*LOGQ-1:0] in_c;
  logic [QIDX_W-1:0] in_qidx;
  logic [TAG_W-1:0] in_tag;
  logic out_valid, out_ready;
  logic [LOGQ-1:0] out_t;
  logic [TAG_W-1:0] out_tag;
  modport master (output in_valid, in_c, in_qidx, in_tag, out_ready,
                  input in_ready, out_valid, out_t, out_tag);
  modport slave (input in_valid, in_c, in_qidx, in_tag, out_ready,
                 output in_ready, out_valid, out_t, out_tag);
endinterface

// File: rtl/wlm_red_pipe_word_step.sv
// wlm_word_step: one registered Montgomery word iteration carrying qH, tag and valid alongside
module wlm_word_step import wlm_pkg::*; #(
  parameter int W = WLM_W,
  parameter int QH_W = WLM_LOGQ - WLM_W,
  parameter int TAG_W = WLM_TAG_W,
  parameter int IW = 2 * WLM_LOGQ,
  parameter int OW = 2 * WLM_LOGQ - WLM_W + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic [IW-1:0] in_t,
  input  logic [QH_W-1:0] in_qh,
  input  logic [TAG_W-1:0] in_tag,
  input  logic in_valid,
  output logic [OW-1:0] out_t,
  output logic [QH_W-1:0] out_qh,
  output logic [TAG_W-1:0] out_tag,
  output logic out_valid
);
  logic [W-1:0] lo, m;
  assign lo = in_t[W-1:0];
  assign m = -lo;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_valid <= 1'b0;
    else if (en) out_valid <= in_valid;
  // Since q = 1 mod 2^W, adding m*q clears the low word exactly; the +1 is the m*1 carry-out
  always_ff @(posedge clk)
    if (en) begin
      out_t <= OW'(in_t >> W) + OW'(m) * OW'(in_qh) + OW'(lo != '0);
      out_qh <= in_qh;
      out_tag <= in_tag;
    end
endmodule

// File: rtl/wlm_red_pipe.sv
// wlm_red_pipe: elastic pipelined word-level Montgomery reducer with a per-request qH table
module wlm_red_pipe import wlm_pkg::*; #(
  parameter int LOGQ = WLM_LOGQ,
  parameter int W = WLM_W,
  parameter int NQ = 4,
  parameter int TAG_W = WLM_TAG_W,
  parameter int FF_OUT = 1,
  localparam int QIDX_W = (NQ > 1) ? $clog2(NQ) : 1,
  localparam int QH_W = LOGQ - W,
  localparam int N_ITER = wlm_n_iter(LOGQ, W),
  localparam int LAT = wlm_lat(LOGQ, W, FF_OUT),
  localparam int CNT_W = $clog2(LAT + 1),
  localparam int FW = wlm_stage_width(LOGQ, W, N_ITER)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_we,
  input  logic [QIDX_W-1:0] cfg_idx,
  input  logic [QH_W-1:0] cfg_qh,
  wlm_red_pipe_if.slave bus,
  output logic busy
);
  logic en, acc, xfer;
  logic [QH_W-1:0] tbl [NQ];
  logic [QH_W-1:0] qh_sel;
  logic [2*LOGQ-1:0] s0_c;
  logic [QH_W-1:0] s0_qh;
  logic [TAG_W-1:0] s0_tag;
  logic s0_v;
  logic [CNT_W-1:0] cnt;
  logic [FW-1:0] tn;
  logic [QH_W-1:0] qn;
  logic [TAG_W-1:0] tagn;
  logic vn;
  logic [LOGQ-1:0] q, res;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign acc = bus.in_valid && en;
  assign xfer = bus.out_valid && bus.out_ready;
  assign busy = cnt != '0;
  assign qh_sel = (int'(bus.in_qidx) < NQ) ? tbl[bus.in_qidx] : tbl[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < NQ; k++) tbl[k] <= '0;
    else if (cfg_we && int'(cfg_idx) < NQ) tbl[cfg_idx] <= cfg_qh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s0_v <= 1'b0;
    else if (en) s0_v <= bus.in_valid;
  always_ff @(posedge clk)
    if (en) begin
      s0_c <= bus.in_c;
      s0_qh <= qh_sel;
      s0_tag <= bus.in_tag;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (acc && !xfer) ? cnt + CNT_W'(1) : (!acc && xfer) ? cnt - CNT_W'(1) : cnt;
  for (genvar i = 0; i < N_ITER; i++) begin : g_s
    localparam int IW = wlm_stage_width(LOGQ, W, i);
    localparam int OW = wlm_stage_width(LOGQ, W, i + 1);
    logic [IW-1:0] ti;
    logic [QH_W-1:0] qhi, qh;
    logic [TAG_W-1:0] tagi, tag;
    logic vi, v;
    logic [OW-1:0] t;
    if (i == 0) begin : g_f
      assign ti = s0_c;
      assign qhi = s0_qh;
      assign tagi = s0_tag;
      assign vi = s0_v;
    end else begin : g_n
      assign ti = g_s[i-1].t;
      assign qhi = g_s[i-1].qh;
      assign tagi = g_s[i-1].tag;
      assign vi = g_s[i-1].v;
    end
    wlm_word_step #(.W(W), .QH_W(QH_W), .TAG_W(TAG_W), .IW(IW), .OW(OW)) u_step (
      .clk(clk), .rst_n(rst_n), .en(en),
      .in_t(ti), .in_qh(qhi), .in_tag(tagi), .in_valid(vi),
      .out_t(t), .out_qh(qh), .out_tag(tag), .out_valid(v)
    );
  end
  assign tn = g_s[N_ITER-1].t;
  assign qn = g_s[N_ITER-1].qh;
  assign tagn = g_s[N_ITER-1].tag;
  assign vn = g_s[N_ITER-1].v;
  assign q = {qn, {(W-1){1'b0}}, 1'b1};
  assign res = LOGQ'((tn >= {1'b0, q}) ? tn - {1'b0, q} : tn);
  if (FF_OUT != 0) begin : g_ff
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) bus.out_valid <= 1'b0;
      else if (en) bus.out_valid <= vn;
    always_ff @(posedge clk)
      if (en) begin
        bus.out_t <= res;
        bus.out_tag <= tagn;
      end
  end else begin : g_comb
    assign bus.out_valid = vn;
    assign bus.out_t = res;
    assign bus.out_tag = tagn;
  end
endmodule

// File: tb/tb_wlm_red_pipe.sv
// tb_wlm_red_pipe: directed self-checking bench for the word-level Montgomery reducer
module tb_wlm_red_pipe;
  import wlm_pkg::*;
  localparam int LAT = 6;
  localparam int NQ = 3;
  typedef struct {
    logic [59:0] t;
    logic [7:0] tag;
    int cyc;
    bit lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [42:0] cfg_qh = '0;
  logic busy;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit lat_mode = 1'b1;
  bit stalled = 1'b0;
  logic [42:0] shadow [NQ];
  exp_t exp_q [$];
  wlm_red_pipe_if #(.LOGQ(60), .QIDX_W(2), .TAG_W(8)) bus ();
  wlm_red_pipe #(.LOGQ(60), .W(17), .NQ(NQ), .TAG_W(8), .FF_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_qh(cfg_qh),
    .bus(bus), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  // Bitwise Montgomery halving: add q when odd, shift, 68 times
  function automatic logic [59:0] mont(input logic [119:0] c, input logic [42:0] qh);
    logic [127:0] q, t;
    q = {68'd0, qh, 17'd1};
    t = {8'd0, c};
    for (int k = 0; k < 68; k++) begin
      if (t[0]) t = t + q;
      t = t >> 1;
    end
    t = t % q;
    return t[59:0];
  endfunction
  task automatic step(input logic v, input logic [119:0] c, input logic [1:0] qi, input logic [7:0] tg,
                      input logic rdy, input logic we, input logic [1:0] wi, input logic [42:0] wq);
    wlm_req_t r;
    exp_t e;
    @(negedge clk);
    cyc++;
    bus.in_valid = v;
    bus.in_c = c;
    bus.in_qidx = qi;
    bus.in_tag = tg;
    bus.out_ready = rdy;
    cfg_we = we;
    cfg_idx = wi;
    cfg_qh = wq;
    #1;
    chk("in_ready", 128'(bus.in_ready), 128'(!bus.out_valid || rdy));
    if (stalled) chk("stall_hold", 128'(bus.out_valid), 128'd1);
    if (exp_q.size() == 0) chk("no_spurious", 128'(bus.out_valid), 128'd0);
    else if (bus.out_valid) begin
      chk("out_t", 128'(bus.out_t), 128'(exp_q[0].t));
      chk("out_tag", 128'(bus.out_tag), 128'(exp_q[0].tag));
      if (rdy) begin
        e = exp_q.pop_front();
        if (e.lat) chk("latency", 128'(cyc - e.cyc), 128'(LAT));
      end
    end
    stalled = bus.out_valid && !rdy;
    r.c = c;
    r.qh = (int'(qi) < NQ) ? shadow[qi] : shadow[0];
    r.tag = tg;
    r.valid = v;
    if (r.valid && bus.in_ready) exp_q.push_back('{mont(r.c, r.qh), r.tag, cyc, lat_mode});
    if (we && int'(wi) < NQ) shadow[wi] = wq;
  endtask
  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
  endtask
  task automatic cfg(input logic [1:0] wi, input logic [42:0] wq);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1, wi, wq);
  endtask
  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle();
    chk("drained", 128'(exp_q.size()), 128'd0);
    idle();
    chk("busy_idle", 128'(busy), 128'd0);
  endtask
  initial begin
    logic [127:0] qq, cc;
    logic [1:0] qi;
    for (int k = 0; k < NQ; k++) shadow[k] = '0;
    bus.in_valid = 1'b0;
    bus.in_c = '0;
    bus.in_qidx = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    rst_n = 1'b1;
    cfg(2'd0, 43'd3);
    cfg(2'd1, 43'd5);
    step(1'b1, 120'd0, 2'd0, 8'hA1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 120'd393217, 2'd0, 8'hA2, 1'b1, 1'b0, '0, '0);
    chk("busy_inflight", 128'(busy), 128'd1);
    drain();
    for (int k = 0; k < 1000; k++) begin
      qi = 2'($urandom_range(1));
      qq = {68'd0, shadow[qi], 17'd1};
      cc = 128'({$urandom, $urandom}) % (qq * qq);
      step(1'b1, cc[119:0], qi, 8'(k), 1'b1, 1'b0, '0, '0);
    end
    drain();
    lat_mode = 1'b0;
    for (int k = 0; k < 300; k++) begin
      qi = 2'($urandom_range(1));
      qq = {68'd0, shadow[qi], 17'd1};
      cc = 128'({$urandom, $urandom}) % (qq * qq);
      step($urandom_range(9) < 7, cc[119:0], qi, 8'(k), $urandom_range(9) >= 3, 1'b0, '0, '0);
    end
    lat_mode = 1'b1;
    drain();
    step(1'b1, 120'd123456789, 2'd0, 8'hB1, 1'b1, 1'b1, 2'd0, 43'd7);
    step(1'b1, 120'd123456789, 2'd0, 8'hB2, 1'b1, 1'b0, '0, '0);
    drain();
    cfg(2'd3, 43'd9);
    step(1'b1, 120'd987654321, 2'd3, 8'hC1, 1'b1, 1'b0, '0, '0);
    qq = {68'd0, 43'd5, 17'd1};
    cc = qq * qq - 128'd1;
    step(1'b1, cc[119:0], 2'd1, 8'hC2, 1'b1, 1'b0, '0, '0);
    cfg(2'd2, 43'h7FF_FFFF_FFFF);
    qq = {68'd0, 43'h7FF_FFFF_FFFF, 17'd1};
    cc = qq * qq - 128'd1;
    step(1'b1, cc[119:0], 2'd2, 8'hC3, 1'b1, 1'b0, '0, '0);
    step(1'b1, cc[119:0] >> 7, 2'd2, 8'hC4, 1'b1, 1'b0, '0, '0);
    drain();
    for (int k = 0; k < 4; k++) step(1'b1, 120'(1000 + k), 2'd1, 8'(8'hD0 + k), 1'b1, 1'b0, '0, '0);
    idle();
    chk("busy_before_rst", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("flush_out_valid", 128'(bus.out_valid), 128'd0);
    chk("flush_busy", 128'(busy), 128'd0);
    exp_q.delete();
    stalled = 1'b0;
    for (int k = 0; k < NQ; k++) shadow[k] = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) idle();
    step(1'b1, 120'd55555, 2'd0, 8'hE1, 1'b1, 1'b0, '0, '0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
